mem_access_unit: RTL

//  Memory-stage bus interface directly downstream of the pipelined datapath.

---
 rtl/mem_pkg.sv | 13 +
 rtl/mem_timeout_ctr.sv | 32 +++
 rtl/mem_access_unit.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared state encoding and constants for the memory-stage bus interface.
package mem_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic [31:0] FaultRdata     = 32'hDEAD_BEEF;
  localparam int unsigned TimeoutDefault = 64;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts bus wait cycles and flags the cycle in which the wait budget runs out.
// Instantiated by mem_access_unit only when MEM_TIMEOUT_EN is defined.
module mem_timeout_ctr
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Fires during the TIMEOUT-th wait cycle so the abort lands exactly after TIMEOUT cycles.
  assign o_expired = i_en && (r_cnt == CntW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_unit.sv
// M-stage req/ack bus master that stalls the pipeline until each load/store completes.
// Optional wait-cycle abort is enabled by defining MEM_TIMEOUT_EN.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemReadM,
  input  logic              MemWriteM,
  input  logic [31:0]       ALUOutM,
  input  logic [31:0]       WriteDataM,
  output logic [31:0]       ReadDataM,
  output logic              StallM,
  output logic              MemFaultM,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata
);

  state_e r_state, w_next;

  logic              r_req, r_we, r_fault;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata, r_rdata;
  logic              w_acc, w_aligned, w_expired;

  assign w_acc     = MemReadM | MemWriteM;
  assign w_aligned = (ALUOutM[1:0] == 2'b00);

`ifdef MEM_TIMEOUT_EN
  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk       (clk),
    .reset     (reset),
    .i_clear   ((r_state == StIdle) && (w_next == StWait)),
    .i_en      (r_state == StWait),
    .o_expired (w_expired)
  );
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
  assign w_expired        = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    StallM = 1'b0;
    case (r_state)
      StIdle: begin
        StallM = w_acc;
        if (w_acc) begin
          w_next = w_aligned ? StWait : StDone;
        end
      end
      StWait: begin
        StallM = 1'b1;
        if (bus_ack || w_expired) begin
          w_next = StDone;
        end
      end
      // One unstalled cycle lets the pipeline retire the access before re-arming.
      StDone:  w_next = StIdle;
      default: w_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_fault <= 1'b0;
    end else begin
      r_fault <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_acc && w_aligned) begin
            r_req   <= 1'b1;
            r_we    <= MemWriteM;
            r_addr  <= ALUOutM[ADDR_W-1:0];
            r_wdata <= WriteDataM;
          end else if (w_acc) begin
            r_fault <= 1'b1;
          end
        end
        StWait: begin
          if (bus_ack) begin
            r_req <= 1'b0;
            if (!r_we) r_rdata <= bus_rdata;
          end else if (w_expired) begin
            r_req   <= 1'b0;
            r_fault <= 1'b1;
            if (!r_we) r_rdata <= FaultRdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign ReadDataM = r_rdata;
  assign MemFaultM = r_fault;
  assign bus_req   = r_req;
  assign bus_we    = r_we;
  assign bus_addr  = r_addr;
  assign bus_wdata = r_wdata;

endmodule
